// File: rtl/spart_pkg.sv
// Shared constants and types for the SPART bus responder and serial engine.
package spart_pkg;

    // Register map seen by the processor-side driver
    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    // Baud enables per serial bit, and derived tick-counter terminal values
    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] OS_LAST    = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] OS_HALF    = 4'(OVERSAMPLE / 2 - 1);

    // Last bit index of a TX frame (start + 8 data + stop) and of RX data
    localparam logic [3:0] TX_STOP_BIT = 4'd9;
    localparam logic [2:0] RX_LAST_BIT = 3'd7;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'b00,
        RX_START = 2'b01,
        RX_DATA  = 2'b10,
        RX_STOP  = 2'b11
    } rx_state_t;

    // Full 10-bit line frame, bit 0 goes out first: start 0, data LSB first, stop 1
    function automatic logic [9:0] tx_frame(input logic [7:0] data);
        return {1'b1, data, 1'b0};
    endfunction

endpackage

// File: rtl/spart_baud_gen.sv
// Baud-rate generator: down-counter reloaded from the divisor, one-cycle
// enable each time it expires. A divisor of 0 yields an enable every cycle.
module spart_baud_gen
    import spart_pkg::*;
#(
    parameter logic [15:0] DB_RESET = 16'h0145
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] db,
    input  logic        reload,
    output logic        baud_en
);

    logic [15:0] cnt_r;
    logic        baud_en_r;

    // Count down; on expiry pulse the enable and restart from the divisor
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r     <= DB_RESET;
            baud_en_r <= 1'b0;
        end else if (reload) begin
            cnt_r     <= db;
            baud_en_r <= 1'b0;
        end else if (cnt_r == 16'd0) begin
            cnt_r     <= db;
            baud_en_r <= 1'b1;
        end else begin
            cnt_r     <= cnt_r - 16'd1;
            baud_en_r <= 1'b0;
        end
    end

    assign baud_en = baud_en_r;

endmodule

// File: rtl/spart.sv
// SPART top: bus register decode, transmit serializer and receive
// deserializer with a single-byte receive buffer.
module spart
    import spart_pkg::*;
#(
    parameter logic [15:0] DB_RESET = 16'h0145
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    logic        rd_s;
    logic        wr_s;
    logic [7:0]  rd_data_s;
    logic [15:0] db_r;
    logic        reload_r;
    logic        baud_en_s;

    assign rd_s = iocs & iorw;
    assign wr_s = iocs & ~iorw;

    // ---------------- divisor registers ----------------
    // Divisor bytes are written from the bus; the counter reload is delayed a
    // cycle so it picks up the freshly written value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_r     <= DB_RESET;
            reload_r <= 1'b0;
        end else begin
            reload_r <= wr_s & ioaddr[1];
            if (wr_s && (ioaddr == ADDR_DBL)) begin
                db_r[7:0] <= databus;
            end else if (wr_s && (ioaddr == ADDR_DBH)) begin
                db_r[15:8] <= databus;
            end else begin
                db_r <= db_r;
            end
        end
    end

    spart_baud_gen #(.DB_RESET(DB_RESET)) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .db      (db_r),
        .reload  (reload_r),
        .baud_en (baud_en_s)
    );

    // ---------------- transmitter ----------------
    tx_state_t  tx_state_r, tx_state_nxt;
    logic [9:0] tx_shift_r, tx_shift_nxt;
    logic [3:0] tx_tick_r,  tx_tick_nxt;
    logic [3:0] tx_bit_r,   tx_bit_nxt;
    logic       txd_r,      txd_nxt;
    logic       tbr_r,      tbr_nxt;
    logic       tx_load_s;

    assign tx_load_s = wr_s & (ioaddr == ADDR_BUF) & tbr_r;

    // TX next state: load a frame when idle, then step one bit per 16 enables
    always_comb begin
        tx_state_nxt = tx_state_r;
        tx_shift_nxt = tx_shift_r;
        tx_tick_nxt  = tx_tick_r;
        tx_bit_nxt   = tx_bit_r;
        txd_nxt      = txd_r;
        tbr_nxt      = tbr_r;
        case (tx_state_r)
            TX_IDLE: begin
                if (tx_load_s) begin
                    tx_state_nxt = TX_SEND;
                    tx_shift_nxt = tx_frame(databus);
                    tx_tick_nxt  = 4'd0;
                    tx_bit_nxt   = 4'd0;
                    txd_nxt      = 1'b0;
                    tbr_nxt      = 1'b0;
                end else begin
                    txd_nxt = 1'b1;
                    tbr_nxt = 1'b1;
                end
            end
            TX_SEND: begin
                if (baud_en_s && (tx_tick_r == OS_LAST)) begin
                    tx_tick_nxt = 4'd0;
                    if (tx_bit_r == TX_STOP_BIT) begin
                        tx_state_nxt = TX_IDLE;
                        txd_nxt      = 1'b1;
                        tbr_nxt      = 1'b1;
                    end else begin
                        tx_bit_nxt   = tx_bit_r + 4'd1;
                        tx_shift_nxt = {1'b1, tx_shift_r[9:1]};
                        txd_nxt      = tx_shift_r[1];
                    end
                end else if (baud_en_s) begin
                    tx_tick_nxt = tx_tick_r + 4'd1;
                end else begin
                    tx_tick_nxt = tx_tick_r;
                end
            end
            default: begin
                tx_state_nxt = TX_IDLE;
                txd_nxt      = 1'b1;
                tbr_nxt      = 1'b1;
            end
        endcase
    end

    // TX state and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_r <= TX_IDLE;
            tx_shift_r <= 10'h3ff;
            tx_tick_r  <= 4'd0;
            tx_bit_r   <= 4'd0;
            txd_r      <= 1'b1;
            tbr_r      <= 1'b1;
        end else begin
            tx_state_r <= tx_state_nxt;
            tx_shift_r <= tx_shift_nxt;
            tx_tick_r  <= tx_tick_nxt;
            tx_bit_r   <= tx_bit_nxt;
            txd_r      <= txd_nxt;
            tbr_r      <= tbr_nxt;
        end
    end

    // ---------------- receiver ----------------
    logic       sync1_r, sync2_r, prev_r;
    rx_state_t  rx_state_r, rx_state_nxt;
    logic [3:0] rx_tick_r,  rx_tick_nxt;
    logic [2:0] rx_bit_r,   rx_bit_nxt;
    logic [7:0] rx_shift_r, rx_shift_nxt;
    logic [7:0] rx_buf_r,   rx_buf_nxt;
    logic       rda_r,      rda_nxt;
    logic       frame_ok_s;

    // Two-flop synchronizer for the asynchronous line, plus a delayed copy
    // used for falling-edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= rxd;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // RX next state: find start edge, confirm at mid-bit, sample data and stop
    always_comb begin
        rx_state_nxt = rx_state_r;
        rx_tick_nxt  = rx_tick_r;
        rx_bit_nxt   = rx_bit_r;
        rx_shift_nxt = rx_shift_r;
        frame_ok_s   = 1'b0;
        case (rx_state_r)
            RX_IDLE: begin
                if (prev_r && !sync2_r) begin
                    rx_state_nxt = RX_START;
                    rx_tick_nxt  = 4'd0;
                end else begin
                    rx_tick_nxt = 4'd0;
                end
            end
            RX_START: begin
                if (baud_en_s && (rx_tick_r == OS_HALF)) begin
                    rx_tick_nxt  = 4'd0;
                    rx_bit_nxt   = 3'd0;
                    rx_state_nxt = sync2_r ? RX_IDLE : RX_DATA;
                end else if (baud_en_s) begin
                    rx_tick_nxt = rx_tick_r + 4'd1;
                end else begin
                    rx_tick_nxt = rx_tick_r;
                end
            end
            RX_DATA: begin
                if (baud_en_s && (rx_tick_r == OS_LAST)) begin
                    rx_tick_nxt  = 4'd0;
                    rx_shift_nxt = {sync2_r, rx_shift_r[7:1]};
                    if (rx_bit_r == RX_LAST_BIT) begin
                        rx_state_nxt = RX_STOP;
                    end else begin
                        rx_bit_nxt = rx_bit_r + 3'd1;
                    end
                end else if (baud_en_s) begin
                    rx_tick_nxt = rx_tick_r + 4'd1;
                end else begin
                    rx_tick_nxt = rx_tick_r;
                end
            end
            RX_STOP: begin
                if (baud_en_s && (rx_tick_r == OS_LAST)) begin
                    rx_tick_nxt  = 4'd0;
                    rx_state_nxt = RX_IDLE;
                    frame_ok_s   = sync2_r;
                end else if (baud_en_s) begin
                    rx_tick_nxt = rx_tick_r + 4'd1;
                end else begin
                    rx_tick_nxt = rx_tick_r;
                end
            end
            default: begin
                rx_state_nxt = RX_IDLE;
            end
        endcase
    end

    // Buffer update: a completed frame wins over a same-cycle buffer read
    always_comb begin
        rx_buf_nxt = rx_buf_r;
        rda_nxt    = rda_r;
        if (frame_ok_s) begin
            rx_buf_nxt = rx_shift_r;
            rda_nxt    = 1'b1;
        end else if (rd_s && (ioaddr == ADDR_BUF)) begin
            rda_nxt = 1'b0;
        end else begin
            rda_nxt = rda_r;
        end
    end

    // RX state, shifter and receive buffer registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_r <= RX_IDLE;
            rx_tick_r  <= 4'd0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
            rx_buf_r   <= 8'h00;
            rda_r      <= 1'b0;
        end else begin
            rx_state_r <= rx_state_nxt;
            rx_tick_r  <= rx_tick_nxt;
            rx_bit_r   <= rx_bit_nxt;
            rx_shift_r <= rx_shift_nxt;
            rx_buf_r   <= rx_buf_nxt;
            rda_r      <= rda_nxt;
        end
    end

    // ---------------- bus read side ----------------
    // Read data mux, presented combinationally while the driver reads
    always_comb begin
        rd_data_s = 8'h00;
        case (ioaddr)
            ADDR_BUF:  rd_data_s = rx_buf_r;
            ADDR_STAT: rd_data_s = {6'b000000, tbr_r, rda_r};
            ADDR_DBL:  rd_data_s = db_r[7:0];
            ADDR_DBH:  rd_data_s = db_r[15:8];
            default:   rd_data_s = 8'h00;
        endcase
    end

    assign databus = rd_s ? rd_data_s : 8'hzz;

    assign rda = rda_r;
    assign tbr = tbr_r;
    assign txd = txd_r;

endmodule
